inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache.sv | 122 ++++++++++++
 tb/tb_inst_cache.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line, with a
// blocking two-state miss handler toward the memory controller.
//
//   state | meaning
//   IDLE  | ready for a fetch; hits are answered the cycle after acceptance
//   MISS  | fill request outstanding; waits for a fill pulse or a redirect
module inst_cache #(
    parameter int INDEX_W = 7,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              is_jump,
    output logic              if_ready,
    output logic [31:0]       if_inst_o,
    output logic              if_inst_valid,
    output logic              icache_needed,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              mem_busy,
    input  logic [31:0]       inst_i,
    input  logic              inst_data_enable
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES];
    logic [ADDR_W-3:0]   r_addr;
    logic [31:0]         r_inst;
    logic                r_inst_valid;
    logic                r_needed;
    logic [ADDR_W-1:0]   r_icache_addr;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_hit;
    logic                w_accept;
    logic                w_fill;
    logic [1:0]          w_unused_addr_lsb;

    assign w_idx      = if_addr[INDEX_W+1:2];
    assign w_tag      = if_addr[ADDR_W-1:INDEX_W+2];
    assign w_fill_idx = r_addr[INDEX_W-1:0];
    assign w_fill_tag = r_addr[ADDR_W-3:INDEX_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept   = (r_state == IDLE) && if_req && !is_jump;
    // A fill lands even when a redirect arrives on the same edge; only reset blocks it.
    assign w_fill     = (r_state == MISS) && inst_data_enable && !rst;

    // Byte-offset bits carry no meaning for word fetches; mem_busy only delays the fill pulse.
    assign w_unused_addr_lsb = if_addr[1:0] & {2{~mem_busy}};

    assign if_ready      = (r_state == IDLE);
    assign if_inst_o     = r_inst;
    assign if_inst_valid = r_inst_valid;
    assign icache_needed = r_needed;
    assign icache_addr   = r_icache_addr;

    // Tag and data storage: written only by a fill, never reset.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= inst_i;
        end
    end

    // Control FSM, valid bits and registered fetch/fill outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_addr        <= '0;
            r_inst        <= '0;
            r_inst_valid  <= 1'b0;
            r_needed      <= 1'b0;
            r_icache_addr <= '0;
        end else begin
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= if_addr[ADDR_W-1:2];
                        if (w_hit) begin
                            r_inst_valid <= 1'b1;
                            r_inst       <= r_data[w_idx];
                        end else begin
                            r_state       <= MISS;
                            r_needed      <= 1'b1;
                            r_icache_addr <= {if_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                MISS: begin
                    if (inst_data_enable) begin
                        r_valid[w_fill_idx] <= 1'b1;
                        if (!is_jump) begin
                            r_inst_valid <= 1'b1;
                            r_inst       <= inst_i;
                        end
                        r_needed <= 1'b0;
                        r_state  <= IDLE;
                    end else if (is_jump) begin
                        r_needed <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hit, conflict, jump abort,
// mem_busy stall, jump/fill collision, IDLE jump, stray fill and reset mid-miss.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        is_jump;
    logic        if_ready;
    logic [31:0] if_inst_o;
    logic        if_inst_valid;
    logic        icache_needed;
    logic [31:0] icache_addr;
    logic        mem_busy;
    logic [31:0] inst_i;
    logic        inst_data_enable;

    int n_checks = 0;
    int n_errors = 0;

    inst_cache #(.INDEX_W(7), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .is_jump          (is_jump),
        .if_ready         (if_ready),
        .if_inst_o        (if_inst_o),
        .if_inst_valid    (if_inst_valid),
        .icache_needed    (icache_needed),
        .icache_addr      (icache_addr),
        .mem_busy         (mem_busy),
        .inst_i           (inst_i),
        .inst_data_enable (inst_data_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle fetch request.
    task automatic fetch(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        step();
        if_req  = 1'b0;
    endtask

    // One-cycle fill pulse.
    task automatic fill(input logic [31:0] d);
        inst_i           = d;
        inst_data_enable = 1'b1;
        step();
        inst_data_enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; is_jump = 1'b0;
        mem_busy = 1'b0; inst_i = '0; inst_data_enable = 1'b0;
        step(); step();
        check("rst_ready",  {31'd0, if_ready}, 32'd1);
        check("rst_valid",  {31'd0, if_inst_valid}, 32'd0);
        check("rst_inst",   if_inst_o, 32'h0);
        check("rst_needed", {31'd0, icache_needed}, 32'd0);
        check("rst_addr",   icache_addr, 32'h0);
        rst = 1'b0;
        step();

        // Cold miss
        fetch(32'h0000_1004);
        check("cold_needed", {31'd0, icache_needed}, 32'd1);
        check("cold_addr",   icache_addr, 32'h0000_1004);
        check("cold_ready",  {31'd0, if_ready}, 32'd0);
        check("cold_novalid", {31'd0, if_inst_valid}, 32'd0);
        step();
        check("cold_hold_addr", icache_addr, 32'h0000_1004);
        fill(32'h00A0_0093);
        check("cold_valid",  {31'd0, if_inst_valid}, 32'd1);
        check("cold_inst",   if_inst_o, 32'h00A0_0093);
        check("cold_drop",   {31'd0, icache_needed}, 32'd0);
        check("cold_ready2", {31'd0, if_ready}, 32'd1);
        step();
        check("pulse_end_valid", {31'd0, if_inst_valid}, 32'd0);
        check("pulse_end_inst",  if_inst_o, 32'h0);

        // Hit
        fetch(32'h0000_1004);
        check("hit_valid",  {31'd0, if_inst_valid}, 32'd1);
        check("hit_inst",   if_inst_o, 32'h00A0_0093);
        check("hit_needed", {31'd0, icache_needed}, 32'd0);

        // Back-to-back hits: request held for two edges
        if_req = 1'b1; if_addr = 32'h0000_1004;
        step();
        check("b2b_1", {31'd0, if_inst_valid}, 32'd1);
        step();
        check("b2b_2", {31'd0, if_inst_valid}, 32'd1);
        check("b2b_inst", if_inst_o, 32'h00A0_0093);
        if_req = 1'b0;
        step();

        // Conflict on the same index
        fetch(32'h0000_1204);
        check("conf_needed", {31'd0, icache_needed}, 32'd1);
        check("conf_addr",   icache_addr, 32'h0000_1204);
        fill(32'h1111_1111);
        check("conf_inst", if_inst_o, 32'h1111_1111);
        fetch(32'h0000_1004);
        check("conf_remiss", {31'd0, icache_needed}, 32'd1);
        check("conf_remiss_valid", {31'd0, if_inst_valid}, 32'd0);
        fill(32'h00A0_0093);
        check("conf_refill", if_inst_o, 32'h00A0_0093);

        // Jump abort three cycles into a miss
        fetch(32'h0000_2000);
        step(); step();
        check("jmp_still_miss", {31'd0, icache_needed}, 32'd1);
        is_jump = 1'b1;
        step();
        is_jump = 1'b0;
        check("jmp_needed", {31'd0, icache_needed}, 32'd0);
        check("jmp_valid",  {31'd0, if_inst_valid}, 32'd0);
        check("jmp_ready",  {31'd0, if_ready}, 32'd1);
        // Stray fill while idle must be ignored
        fill(32'hDEAD_BEEF);
        check("stray_valid", {31'd0, if_inst_valid}, 32'd0);
        check("stray_inst",  if_inst_o, 32'h0);
        fetch(32'h0000_2000);
        check("jmp_remiss", {31'd0, icache_needed}, 32'd1);

        // mem_busy stall
        mem_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("busy_needed", {31'd0, icache_needed}, 32'd1);
            check("busy_addr",   icache_addr, 32'h0000_2000);
        end
        mem_busy = 1'b0;
        fill(32'h2222_2222);
        check("busy_fill_valid", {31'd0, if_inst_valid}, 32'd1);
        check("busy_fill_inst",  if_inst_o, 32'h2222_2222);
        fetch(32'h0000_2000);
        check("busy_hit", if_inst_o, 32'h2222_2222);

        // Jump and fill on the same edge
        fetch(32'h0000_3008);
        check("coll_needed", {31'd0, icache_needed}, 32'd1);
        is_jump = 1'b1;
        fill(32'h3333_3333);
        is_jump = 1'b0;
        check("coll_valid",  {31'd0, if_inst_valid}, 32'd0);
        check("coll_needed0", {31'd0, icache_needed}, 32'd0);
        check("coll_ready",  {31'd0, if_ready}, 32'd1);
        fetch(32'h0000_3008);
        check("coll_hit_valid", {31'd0, if_inst_valid}, 32'd1);
        check("coll_hit_inst",  if_inst_o, 32'h3333_3333);
        check("coll_hit_needed", {31'd0, icache_needed}, 32'd0);

        // Jump in IDLE blocks acceptance
        is_jump = 1'b1;
        fetch(32'h0000_1004);
        is_jump = 1'b0;
        check("idle_jmp_valid",  {31'd0, if_inst_valid}, 32'd0);
        check("idle_jmp_needed", {31'd0, icache_needed}, 32'd0);
        check("idle_jmp_ready",  {31'd0, if_ready}, 32'd1);

        // Reset mid-miss
        fetch(32'h0000_4000);
        check("rmm_needed", {31'd0, icache_needed}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rmm_drop",  {31'd0, icache_needed}, 32'd0);
        check("rmm_addr",  icache_addr, 32'h0);
        check("rmm_ready", {31'd0, if_ready}, 32'd1);
        fill(32'h4444_4444);
        check("rmm_late_fill", {31'd0, if_inst_valid}, 32'd0);
        fetch(32'h0000_1004);
        check("rmm_cold_again", {31'd0, icache_needed}, 32'd1);
        check("rmm_cold_novalid", {31'd0, if_inst_valid}, 32'd0);
        is_jump = 1'b1;
        step();
        is_jump = 1'b0;
        check("rmm_abort", {31'd0, icache_needed}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
